// File: rtl/oled_refresh_ctrl.sv
// rtl/oled_refresh_ctrl.sv - OLED frame refresh sequencer: address-setup commands then framebuffer bytes to an SPI shifter
//
// Ports:
//   clock        single rising-edge clock
//   reset        synchronous active-high reset
//   enable       panel powered and ready; gates frame start, aborts a frame when low
//   refresh_req  single-cycle request to push one full frame
//   fb_addr      framebuffer byte address (page*COLS + col)
//   fb_data      framebuffer read data, valid one cycle after fb_addr
//   tx_byte      byte to the SPI byte shifter
//   tx_dc        0 = command byte, 1 = display data byte
//   tx_valid     tx_byte/tx_dc valid
//   tx_ready     shifter accepts when high together with tx_valid
//   busy         high from frame start through the last accepted data byte
//   frame_done   one-cycle pulse after the last data byte of a frame is accepted

module oled_refresh_ctrl #(
    parameter int COLS  = 128,
    parameter int PAGES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       refresh_req,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [9:0] LAST_ADDR = 10'(COLS * PAGES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0] state;
    logic [2:0] cmd_idx;
    logic       pending;
    logic       accept;

    assign accept = tx_valid & tx_ready;

    // Address-window setup: horizontal addressing mode, full column range,
    // full page range.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h20;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h21;
            3'd3:    b = 8'h00;
            3'd4:    b = 8'(COLS - 1);
            3'd5:    b = 8'h22;
            3'd6:    b = 8'h00;
            default: b = 8'(PAGES - 1);
        endcase
        return b;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_idx    <= 3'd0;
            pending    <= 1'b0;
            fb_addr    <= 10'd0;
            tx_byte    <= 8'h00;
            tx_dc      <= 1'b0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Any request outside IDLE (including the DONE cycle) is remembered
            // once; the abort path below overrides this by clearing it.
            if (refresh_req && state != S_IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (enable && (refresh_req || pending)) begin
                        state    <= S_CMD;
                        cmd_idx  <= 3'd0;
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        fb_addr  <= 10'd0;
                        tx_byte  <= cmd_byte(3'd0);
                        tx_dc    <= 1'b0;
                        tx_valid <= 1'b1;
                    end
                end

                S_CMD: begin
                    if (accept) begin
                        if (!enable) begin
                            state    <= S_IDLE;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            pending  <= 1'b0;
                        end else if (cmd_idx == 3'd7) begin
                            state    <= S_FETCH;
                            tx_valid <= 1'b0;
                        end else begin
                            cmd_idx <= cmd_idx + 3'd1;
                            tx_byte <= cmd_byte(cmd_idx + 3'd1);
                        end
                    end
                end

                // fb_addr is already on the bus; the memory samples it this cycle.
                S_FETCH: begin
                    if (!enable) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        pending <= 1'b0;
                    end else begin
                        state <= S_RDWAIT;
                    end
                end

                S_RDWAIT: begin
                    if (!enable) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        pending <= 1'b0;
                    end else begin
                        state    <= S_DATA;
                        tx_byte  <= fb_data;
                        tx_dc    <= 1'b1;
                        tx_valid <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        tx_valid <= 1'b0;
                        if (!enable) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            pending <= 1'b0;
                        end else if (fb_addr == LAST_ADDR) begin
                            state      <= S_DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            fb_addr <= fb_addr + 10'd1;
                            state   <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
